// File: rtl/mcp_core_hs.sv
// Multicycle MIPS-subset core (lw/sw/add/sub/and/or/slt/addi/beq/j) on a unified req/ready memory.
// Define MCP_PERF_CNT_EN to add the instret_o32/cycle_o32 performance counters.
module mcp_core_hs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o32,
  output logic [31:0] mem_wdata_o32,
  input  logic [31:0] mem_rdata_i32,
  input  logic        mem_ready_i,
  output logic        halted_o,
`ifdef MCP_PERF_CNT_EN
  output logic [31:0] instret_o32,
  output logic [31:0] cycle_o32,
`endif
  output logic [31:0] pc_o32
);

  localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, ir, dr, a, b, aluout;
  logic [31:0] rf [NUM_REGS];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] signimm, alu_res, rs_val, rt_val;
  logic        funct_ok, xfer;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign opcode  = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign funct   = ir[5:0];
  assign signimm = {{16{ir[15]}}, ir[15:0]};

  function automatic logic [31:0] rf_read(input logic [4:0] idx);
    if (idx == '0 || 32'(idx) >= NUM_REGS) return '0;
    return rf[idx[AW-1:0]];
  endfunction

  assign rs_val = rf_read(rs);
  assign rt_val = rf_read(rt);

  always_comb begin
    funct_ok = 1'b1;
    alu_res  = '0;
    unique case (funct)
      6'h20: alu_res = a + b;
      6'h22: alu_res = a - b;
      6'h24: alu_res = a & b;
      6'h25: alu_res = a | b;
      6'h2A: alu_res = {31'b0, $signed(a) < $signed(b)};
      default: funct_ok = 1'b0;
    endcase
  end

  // Request is gated by reset_ni so the bus goes idle the instant reset asserts.
  assign mem_req_o     = reset_ni && (state == S_FETCH || state == S_MEMRD || state == S_MEMWR);
  assign mem_we_o      = reset_ni && (state == S_MEMWR);
  assign mem_addr_o32  = (state == S_FETCH) ? pc : aluout;
  assign mem_wdata_o32 = (state == S_MEMWR) ? b : '0;
  assign halted_o      = (state == S_HALT);
  assign pc_o32        = pc;
  assign xfer          = mem_req_o && mem_ready_i;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state <= S_FETCH;
    else           state <= state_n;
  end

  always_comb begin
    state_n  = state;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = aluout;
    unique case (state)
      S_FETCH:  if (xfer) state_n = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_RTYPE:     state_n = funct_ok ? S_EXEC : S_HALT;
          OP_ADDI:      state_n = S_ADDIEX;
          OP_BEQ:       state_n = S_BRANCH;
          OP_J:         state_n = S_JUMP;
          default:      state_n = S_HALT;
        endcase
      end
      S_MEMADR: state_n = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (xfer) state_n = S_MEMWB;
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_wdata = dr;
        state_n  = S_FETCH;
      end
      S_MEMWR:  if (xfer) state_n = S_FETCH;
      S_EXEC:   state_n = S_ALUWB;
      S_ALUWB: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        state_n  = S_FETCH;
      end
      S_ADDIEX: state_n = S_ADDIWB;
      S_ADDIWB: begin
        rf_we   = 1'b1;
        state_n = S_FETCH;
      end
      S_BRANCH, S_JUMP: state_n = S_FETCH;
      S_HALT:   state_n = S_HALT;
      default:  state_n = S_HALT;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pc     <= RESET_PC;
      ir     <= '0;
      dr     <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      unique case (state)
        S_FETCH: if (xfer) begin
          ir <= mem_rdata_i32;
          pc <= pc + 32'd4;
        end
        S_DECODE: begin
          a      <= rs_val;
          b      <= rt_val;
          aluout <= pc + (signimm << 2);
        end
        S_MEMADR, S_ADDIEX: aluout <= a + signimm;
        S_MEMRD:  if (xfer) dr <= mem_rdata_i32;
        S_EXEC:   aluout <= alu_res;
        S_BRANCH: if (a == b) pc <= aluout;
        S_JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
        default: ;
      endcase
      if (rf_we && rf_waddr != '0 && 32'(rf_waddr) < NUM_REGS)
        rf[rf_waddr[AW-1:0]] <= rf_wdata;
    end
  end

`ifdef MCP_PERF_CNT_EN
  logic retire;
  assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_ADDIWB) ||
                  (state == S_BRANCH) || (state == S_JUMP) || (state == S_MEMWR && xfer);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cycle_o32   <= '0;
      instret_o32 <= '0;
    end else if (state != S_HALT) begin
      cycle_o32 <= cycle_o32 + 32'd1;
      if (retire) instret_o32 <= instret_o32 + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mcp_core_hs.sv
// Directed bench for mcp_core_hs: two cores (default and NUM_REGS=8/RESET_PC=0x2000_0000)
// each backed by a small memory model with programmable wait states.
module tb_mcp_core_hs;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_na, req_a, we_a, ready_a, halted_a;
  logic [31:0] addr_a, wdata_a, rdata_a, pc_a;
  logic        reset_nb, req_b, we_b, ready_b, halted_b;
  logic [31:0] addr_b, wdata_b, rdata_b, pc_b;
`ifdef MCP_PERF_CNT_EN
  logic [31:0] instret_a, cycle_a, instret_b, cycle_b;
`endif

  mcp_core_hs u_dut_a (
    .clk_i(clk), .reset_ni(reset_na), .mem_req_o(req_a), .mem_we_o(we_a),
    .mem_addr_o32(addr_a), .mem_wdata_o32(wdata_a), .mem_rdata_i32(rdata_a),
    .mem_ready_i(ready_a), .halted_o(halted_a),
`ifdef MCP_PERF_CNT_EN
    .instret_o32(instret_a), .cycle_o32(cycle_a),
`endif
    .pc_o32(pc_a)
  );

  mcp_core_hs #(.RESET_PC(32'h2000_0000), .NUM_REGS(8)) u_dut_b (
    .clk_i(clk), .reset_ni(reset_nb), .mem_req_o(req_b), .mem_we_o(we_b),
    .mem_addr_o32(addr_b), .mem_wdata_o32(wdata_b), .mem_rdata_i32(rdata_b),
    .mem_ready_i(ready_b), .halted_o(halted_b),
`ifdef MCP_PERF_CNT_EN
    .instret_o32(instret_b), .cycle_o32(cycle_b),
`endif
    .pc_o32(pc_b)
  );

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [1024];
  int unsigned wait_a, cnt_a;
  logic        stall_a;
  logic        ld_en, ld_sel;
  logic [11:0] ld_addr;
  logic [31:0] ld_data;

  assign ready_a = req_a && !stall_a && (cnt_a == wait_a);
  assign rdata_a = mem_a[addr_a[9:2]];
  assign ready_b = req_b;
  assign rdata_b = mem_b[addr_b[11:2]];

  always @(posedge clk) begin
    if (!req_a || ready_a) cnt_a <= 0;
    else                   cnt_a <= cnt_a + 1;
    if (ld_en && !ld_sel)              mem_a[ld_addr[9:2]] <= ld_data;
    else if (req_a && we_a && ready_a) mem_a[addr_a[9:2]]  <= wdata_a;
    if (ld_en && ld_sel)               mem_b[ld_addr[11:2]] <= ld_data;
    else if (req_b && we_b && ready_b) mem_b[addr_b[11:2]]  <= wdata_b;
  end

  logic        sel_b;
  logic        s_req, s_we, s_ready, s_halted;
  logic [31:0] s_addr, s_wdata, s_pc;
  assign s_req    = sel_b ? req_b    : req_a;
  assign s_we     = sel_b ? we_b     : we_a;
  assign s_ready  = sel_b ? ready_b  : ready_a;
  assign s_halted = sel_b ? halted_b : halted_a;
  assign s_addr   = sel_b ? addr_b   : addr_a;
  assign s_wdata  = sel_b ? wdata_b  : wdata_a;
  assign s_pc     = sel_b ? pc_b     : pc_a;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input logic sel, input logic [11:0] addr, input logic [31:0] data);
    ld_sel  = sel;
    ld_addr = addr;
    ld_data = data;
    ld_en   = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  // Skips fetches until the core presents exp_addr, then checks every wait cycle and the completion.
  task automatic wait_access(input string tag, input logic exp_we, input logic [31:0] exp_addr,
                             input logic [31:0] exp_data, input int exp_waits);
    int n = 0;
    int waits = 0;
    bit seen = 0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      if (s_req && s_addr == exp_addr) seen = 1;
    end
    if (!seen) begin
      check({tag, " seen"}, 32'd0, 32'd1);
      return;
    end
    while (!s_ready && waits < 50) begin
      check({tag, " hold req"}, {31'b0, s_req}, 32'd1);
      check({tag, " hold we"}, {31'b0, s_we}, {31'b0, exp_we});
      check({tag, " hold addr"}, s_addr, exp_addr);
      if (exp_we) check({tag, " hold wdata"}, s_wdata, exp_data);
      @(negedge clk);
      waits++;
    end
    check({tag, " waits"}, waits, exp_waits);
    check({tag, " we"}, {31'b0, s_we}, {31'b0, exp_we});
    check({tag, " addr"}, s_addr, exp_addr);
    if (exp_we) check({tag, " wdata"}, s_wdata, exp_data);
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!s_halted && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, " halted"}, {31'b0, s_halted}, 32'd1);
    check({tag, " req"}, {31'b0, s_req}, 32'd0);
  endtask

  initial begin
    reset_na = 1'b0; reset_nb = 1'b0;
    wait_a = 0; stall_a = 1'b0; sel_b = 1'b0;
    ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;

    // Program 1: ALU ops, store/load through wait states, $0 write, illegal opcode.
    load(0, 12'h000, 32'h2001_0005);  // addi $1,$0,5
    load(0, 12'h004, 32'h0021_1020);  // add  $2,$1,$1
    load(0, 12'h008, 32'hAC02_0040);  // sw   $2,0x40($0)
    load(0, 12'h00C, 32'h8C03_0040);  // lw   $3,0x40($0)
    load(0, 12'h010, 32'hAC03_0044);  // sw   $3,0x44($0)
    load(0, 12'h014, 32'h2000_0007);  // addi $0,$0,7
    load(0, 12'h018, 32'hAC00_0048);  // sw   $0,0x48($0)
    load(0, 12'h01C, 32'h0022_2022);  // sub  $4,$1,$2
    load(0, 12'h020, 32'h0081_282A);  // slt  $5,$4,$1
    load(0, 12'h024, 32'h0024_3024);  // and  $6,$1,$4
    load(0, 12'h028, 32'h0022_3825);  // or   $7,$1,$2
    load(0, 12'h02C, 32'hAC04_0050);
    load(0, 12'h030, 32'hAC05_0054);
    load(0, 12'h034, 32'hAC06_0058);
    load(0, 12'h038, 32'hAC07_005C);
    load(0, 12'h03C, 32'hFC00_0000);  // opcode 0x3F
    @(negedge clk);
    check("rst req", {31'b0, req_a}, 32'd0);
    check("rst we", {31'b0, we_a}, 32'd0);
    check("rst halted", {31'b0, halted_a}, 32'd0);
    check("rst addr", addr_a, 32'h0);
    check("rst wdata", wdata_a, 32'h0);
    check("rst pc", pc_a, 32'h0);
`ifdef MCP_PERF_CNT_EN
    check("rst cycle", cycle_a, 32'd0);
    check("rst instret", instret_a, 32'd0);
`endif
    reset_na = 1'b1;
    #1;
    check("first req", {31'b0, req_a}, 32'd1);
    check("first addr", addr_a, 32'h0);
    repeat (8) @(negedge clk);
    check("pc after add", pc_a, 32'h8);
    check("fetch 0x08", addr_a, 32'h8);
    wait_a = 3;
    wait_access("sw $2", 1'b1, 32'h40, 32'd10, 3);
    wait_access("lw $3", 1'b0, 32'h40, 32'd0, 3);
    wait_access("sw $3", 1'b1, 32'h44, 32'd10, 3);
    wait_access("sw $0", 1'b1, 32'h48, 32'd0, 3);
    wait_access("sub", 1'b1, 32'h50, 32'hFFFF_FFFB, 3);
    wait_access("slt", 1'b1, 32'h54, 32'd1, 3);
    wait_access("and", 1'b1, 32'h58, 32'd1, 3);
    wait_access("or", 1'b1, 32'h5C, 32'd15, 3);
    wait_halt("op 3F");
    repeat (5) @(negedge clk);
    check("halt sticky", {31'b0, halted_a}, 32'd1);
    check("halt req", {31'b0, req_a}, 32'd0);
    check("halt pc", pc_a, 32'h40);

    // Program 2: beq not-taken then taken backwards, zero-wait.
    reset_na = 1'b0;
    wait_a = 0;
    load(0, 12'h000, 32'h2001_0005);  // addi $1,$0,5
    load(0, 12'h004, 32'h2002_0009);  // addi $2,$0,9
    load(0, 12'h008, 32'h2003_0001);  // addi $3,$0,1
    load(0, 12'h00C, 32'h1022_000A);  // beq $1,$2,+10 (not taken)
    load(0, 12'h010, 32'h1021_FFFE);  // beq $1,$1,-2 -> 0x0C
    @(negedge clk);
    reset_na = 1'b1;
    repeat (13) @(negedge clk);
    check("pc in decode", pc_a, 32'h10);
    repeat (2) @(negedge clk);
    check("beq ne req", {31'b0, req_a}, 32'd1);
    check("beq ne next", addr_a, 32'h10);
`ifdef MCP_PERF_CNT_EN
    check("cycle 15", cycle_a, 32'd15);
    check("instret 4", instret_a, 32'd4);
`endif
    repeat (3) @(negedge clk);
    check("beq eq next", addr_a, 32'h0C);
    check("beq eq pc", pc_a, 32'h0C);
`ifdef MCP_PERF_CNT_EN
    check("cycle 18", cycle_a, 32'd18);
    check("instret 5", instret_a, 32'd5);
`endif
    repeat (3) @(negedge clk);
    check("loop next", addr_a, 32'h10);

    // Program 3: reset lands while a load is stalled.
    reset_na = 1'b0;
    load(0, 12'h000, 32'h2001_0005);  // addi $1,$0,5
    load(0, 12'h004, 32'h8C01_0040);  // lw $1,0x40($0)
    @(negedge clk);
    reset_na = 1'b1;
    repeat (6) @(negedge clk);
    stall_a = 1'b1;
    @(negedge clk);
    check("memrd req", {31'b0, req_a}, 32'd1);
    check("memrd addr", addr_a, 32'h40);
    repeat (2) @(negedge clk);
    reset_na = 1'b0;
    #1;
    check("abort req", {31'b0, req_a}, 32'd0);
    check("abort we", {31'b0, we_a}, 32'd0);
    check("abort addr", addr_a, 32'h0);
    check("abort pc", pc_a, 32'h0);
`ifdef MCP_PERF_CNT_EN
    check("abort cycle", cycle_a, 32'd0);
    check("abort instret", instret_a, 32'd0);
`endif
    load(0, 12'h000, 32'hAC01_0044);  // sw $1,0x44($0)
    stall_a = 1'b0;
    @(negedge clk);
    reset_na = 1'b1;
    #1;
    check("restart addr", addr_a, 32'h0);
    wait_access("sw $1 post", 1'b1, 32'h44, 32'd0, 0);

    // Core B: jump keeps PC[31:28]; out-of-range register writes are dropped.
    sel_b = 1'b1;
    load(1, 12'h000, 32'h0800_0100);  // j 0x100
    load(1, 12'h400, 32'h2009_0005);  // addi $9,$0,5
    load(1, 12'h404, 32'hAC09_0040);  // sw $9,0x40($0)
    load(1, 12'h408, 32'h2007_0003);  // addi $7,$0,3
    load(1, 12'h40C, 32'hAC07_0044);  // sw $7,0x44($0)
    load(1, 12'h410, 32'h0000_0000);  // R-type funct 0: unsupported
    @(negedge clk);
    check("b rst req", {31'b0, req_b}, 32'd0);
    check("b rst addr", addr_b, 32'h2000_0000);
`ifdef MCP_PERF_CNT_EN
    check("b rst cycle", cycle_b, 32'd0);
    check("b rst instret", instret_b, 32'd0);
`endif
    reset_nb = 1'b1;
    #1;
    check("b first addr", addr_b, 32'h2000_0000);
    repeat (3) @(negedge clk);
    check("j target", addr_b, 32'h2000_0400);
    wait_access("sw $9", 1'b1, 32'h40, 32'd0, 0);
    wait_access("sw $7", 1'b1, 32'h44, 32'd3, 0);
    wait_halt("bad funct");
    check("b halt pc", s_pc, 32'h2000_0414);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mcp_core_hs.md
Name: mcp_core_hs

Overview:
- Parametrised multicycle MIPS-subset core: datapath plus integrated control FSM in one block.
- Talks to a single unified instruction/data memory over a req/ready handshake, so memory may insert any number of wait states.
- Provides full next-PC logic (sequential, beq, j), a configurable register count and a halt state for illegal opcodes.
- Sits between the top-level testbench/SoC memory model and nothing else; it replaces the separate datapath/controller pair.

Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset.
- NUM_REGS, 32, number of implemented GPRs; power of two, 2..32.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- mem_req_o  out  1  memory request valid.
- mem_we_o  out  1  1 = write, 0 = read; valid while mem_req_o is high.
- mem_addr_o32  out  32  byte address.
- mem_wdata_o32  out  32  store data.
- mem_rdata_i32  in  32  read data; sampled when mem_req_o and mem_ready_i are both high.
- mem_ready_i  in  1  transaction complete this cycle.
- halted_o  out  1  core stopped on an illegal opcode.
- pc_o32  out  32  current architectural PC.

Behaviour:
- Reset (async, low):
  - state=FETCH, PC=RESET_PC.
  - IR, DR, A, B, ALUOut cleared to 0; registers cleared to 0.
  - While reset_ni is low: mem_req_o=0, mem_we_o=0, halted_o=0, mem_addr_o32=RESET_PC, mem_wdata_o32=0.
  - Reset asserted mid-transaction abandons it; no register or PC update happens.
- Handshake:
  - mem_req_o, mem_we_o, mem_addr_o32 and mem_wdata_o32 are decoded from state/registers and stay stable until mem_ready_i is sampled high.
  - mem_ready_i may be high in the same cycle req rises (zero-wait).
  - mem_ready_i is ignored when req is low.
  - The FSM holds its state while req=1 and ready=0.
- Supported instructions: lw, sw, R-type add/sub/and/or/slt (funct 20/22/24/25/2A hex), addi, beq, j.
- Any other opcode, or an unsupported R-type funct, goes to HALT.
- FSM states and actions:
  - FETCH: req read at PC. On ready: IR<=rdata, PC<=PC+4, go to DECODE.
  - DECODE: A<=rf[rs], B<=rf[rt], ALUOut<=PC+(signimm<<2). Dispatch on opcode:
    - lw/sw -> MEMADR
    - R-type -> EXEC
    - addi -> ADDIEX
    - beq -> BRANCH
    - j -> JUMP
    - else -> HALT
  - MEMADR: ALUOut<=A+signimm. Go to MEMRD (lw) or MEMWR (sw).
  - MEMRD: req read at ALUOut. On ready: DR<=rdata, go to MEMWB.
  - MEMWB: rf[rt]<=DR, go to FETCH.
  - MEMWR: req write, addr=ALUOut, wdata=B. On ready go to FETCH.
  - EXEC: ALUOut<=A op B, go to ALUWB.
  - ALUWB: rf[rd]<=ALUOut, go to FETCH.
  - ADDIEX: ALUOut<=A+signimm, go to ADDIWB.
  - ADDIWB: rf[rt]<=ALUOut, go to FETCH.
  - BRANCH: if A==B then PC<=ALUOut. Go to FETCH.
  - JUMP: PC<={PC[31:28],IR[25:0],2'b00}, go to FETCH.
  - HALT: terminal; halted_o=1, req=0. Left only by reset.
- Instruction latency with zero-wait memory:
  - lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Each wait cycle adds 1.
- Register file:
  - Register 0 reads 0; writes to it are dropped.
  - Register index >= NUM_REGS reads 0; writes to it are dropped.
  - Writes happen on the clock edge.
- Arithmetic:
  - 32-bit wrap-around, no overflow trap.
  - slt is signed.
  - signimm is the sign-extended IR[15:0].
  - PC+4 wraps at 2^32.
- pc_o32 reflects the PC register. It has already advanced by +4 from DECODE onward.

Optional Feature:
- Macro: MCP_PERF_CNT_EN.
- Defined: adds outputs instret_o32 and cycle_o32.
  - Both reset to 0 and wrap at 2^32.
  - cycle_o32 increments every cycle outside reset and HALT.
  - instret_o32 increments on the last cycle of each completed instruction:
    - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP;
    - MEMWR when ready.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Release reset, ready tied 1 -> first req read at 0x0. addi $1,$0,5 then add $2,$1,$1 -> rf[2]=10 after 8 cycles, pc_o32=0x8.
- sw $2,0x40($0) then lw $3,0x40($0), ready delayed 3 cycles per access -> write addr 0x40 data 10; rf[3]=10. Addr/we/wdata stable through every wait cycle.
- beq with $1==$1, imm=-2 at 0x10 -> next fetch 0x0C. beq with unequal operands -> next fetch 0x14.
- j target 0x100 at PC 0x2000_0000 -> next fetch 0x2000_0400.
- Illegal opcode 0x3F -> halted_o=1, req=0 permanently. addi $0,$0,7 -> $0 stays 0. NUM_REGS=8 with write to $9 -> reads back 0.
- Assert reset_ni mid MEMRD with ready low -> req drops immediately. After release, fetch restarts at RESET_PC and rf[rt] is unchanged. With MCP_PERF_CNT_EN defined, both counters read 0.
